// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI/LO registers.
// One bit per cycle: 32 ITER cycles plus a FIX cycle for sign correction and write-back.
module mul_div_unit #(
    parameter logic [31:0] DBZ_QUOT = 32'hFFFFFFFF,
    parameter int unsigned OP_W     = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [31:0]     a_i,
    input  logic [31:0]     b_i,
    input  logic            flush_i,
    output logic [31:0]     hi_o,
    output logic [31:0]     lo_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [OP_W-1:0] OpMult  = OP_W'('h18);
    localparam logic [OP_W-1:0] OpMultu = OP_W'('h19);
    localparam logic [OP_W-1:0] OpDiv   = OP_W'('h1A);
    localparam logic [OP_W-1:0] OpDivu  = OP_W'('h1B);
    localparam logic [OP_W-1:0] OpMthi  = OP_W'('h11);
    localparam logic [OP_W-1:0] OpMtlo  = OP_W'('h13);

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] a_q, b_q, a_raw_q;
    logic [63:0] acc_q;
    logic        div_q, neg_res_q, neg_rem_q, dbz_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        busy, accept, go, op_sgn, op_div;
    logic [32:0] mul_sum, rem_sh;
    logic [33:0] div_diff;
    logic [63:0] acc_step, prod;
    logic [31:0] quot, rem, hi_fix, lo_fix;

    assign busy   = (state_q != StIdle);
    assign accept = start_i && !busy && !flush_i;
    assign op_sgn = (op_i == OpMult) || (op_i == OpDiv);
    assign op_div = (op_i == OpDiv) || (op_i == OpDivu);
    assign go     = accept && (op_i == OpMult || op_i == OpMultu || op_div);

    // Multiply: right-shifting shift-add; the multiplier is consumed LSB first from b_q.
    // Divide: restoring division; remainder in acc[63:32], quotient in acc[31:0],
    // dividend bits fed MSB first from a_q.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
        rem_sh   = {acc_q[63:32], a_q[31]};
        div_diff = {1'b0, rem_sh} - {2'b00, b_q};
        if (div_q) begin
            if (div_diff[33]) begin
                acc_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
                acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc_q[31:1]};
        end
    end

    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
        rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
        if (!div_q) begin
            hi_fix = prod[63:32];
            lo_fix = prod[31:0];
        end else if (dbz_q) begin
            hi_fix = a_raw_q;
            lo_fix = DBZ_QUOT;
        end else begin
            hi_fix = rem;
            lo_fix = quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (go) state_d = StIter;
            StIter: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = busy;
        done_o = done_q;
        hi_o   = hi_q;
        lo_o   = lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            acc_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StFix) && !flush_i;
            if (accept && op_i == OpMthi) hi_q <= a_i;
            if (accept && op_i == OpMtlo) lo_q <= a_i;
            if (go) begin
                a_q       <= (op_sgn && a_i[31]) ? -a_i : a_i;
                b_q       <= (op_sgn && b_i[31]) ? -b_i : b_i;
                a_raw_q   <= a_i;
                div_q     <= op_div;
                neg_res_q <= op_sgn && (a_i[31] ^ b_i[31]);
                neg_rem_q <= op_sgn && a_i[31];
                dbz_q     <= op_div && (b_i == 32'd0);
                acc_q     <= '0;
                cnt_q     <= '0;
            end else if (state_q == StIter && !flush_i) begin
                acc_q <= acc_step;
                a_q   <= div_q ? {a_q[30:0], 1'b0} : a_q;
                b_q   <= div_q ? b_q : {1'b0, b_q[31:1]};
                cnt_q <= cnt_q + 5'd1;
            end else if (state_q == StFix && !flush_i) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

endmodule
